// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-to-1 round-robin channel multiplexer.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Lowest bit position of channel k inside a packed N*W data bus.
  function automatic int unsigned chan_lo(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first valid channel after ptr, wrapping modulo N.
module rr_pick
  import mux_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned SW = $clog2(N)
) (
  input  logic [N-1:0]  v,
  input  logic [SW-1:0] ptr,
  output logic          found,
  output logic [SW-1:0] idx
);

  int unsigned k;

  // Offsets 1..N visit ptr+1 first and ptr itself last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    k     = 0;
    for (int unsigned o = 1; o <= N; o++) begin
      k = (32'(ptr) + o) % N;
      if (!found && v[SW'(k)]) begin
        found = 1'b1;
        idx   = SW'(k);
      end
    end
  end

endmodule

// File: rtl/mux_nto1_rr.sv
// N-to-1 channel mux with fixed-select or round-robin arbitration and a one-entry output buffer.
// Optional feature: define MUX_PARITY_EN to add the registered y_par output.
module mux_nto1_rr
  import mux_pkg::*;
#(
  parameter  int unsigned N  = 4,
  parameter  int unsigned W  = 8,
  localparam int unsigned SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] I,
  input  logic [N-1:0]   v,
  input  logic [SW-1:0]  s,
  input  logic           mode,
  input  logic           rdy,
  output logic [N-1:0]   ack,
  output logic [W-1:0]   y,
  output logic           y_vld,
`ifdef MUX_PARITY_EN
  output logic           y_par,
`endif
  output logic [SW-1:0]  gnt
);

  logic [SW-1:0] ptr_q, ptr_d;
  logic [W-1:0]  y_q, y_d;
  logic          y_vld_q, y_vld_d;
  logic [SW-1:0] gnt_q, gnt_d;
`ifdef MUX_PARITY_EN
  logic          par_q, par_d;
`endif

  logic          rr_found;
  logic [SW-1:0] rr_idx;
  logic          cand;
  logic [SW-1:0] cidx;
  logic          ld_ok;
  logic          load;
  logic [W-1:0]  sel_word;

  rr_pick #(
    .N  (N),
    .SW (SW)
  ) u_pick (
    .v     (v),
    .ptr   (ptr_q),
    .found (rr_found),
    .idx   (rr_idx)
  );

  // Candidate selection; an out-of-range fixed select yields no candidate.
  always_comb begin
    cand = 1'b0;
    cidx = '0;
    if (mode == MODE_FIXED) begin
      if (32'(s) < N) begin
        cand = v[s];
        cidx = s;
      end
    end else begin
      cand = rr_found;
      cidx = rr_idx;
    end
  end

  assign ld_ok    = !y_vld_q || rdy;
  assign load     = !rst && ld_ok && cand;
  assign ack      = load ? (N'(1) << cidx) : '0;
  assign sel_word = I[chan_lo(32'(cidx), W) +: W];

  // Output buffer next state: load wins, otherwise a consumed word empties the buffer.
  always_comb begin
    ptr_d   = ptr_q;
    y_d     = y_q;
    y_vld_d = y_vld_q;
    gnt_d   = gnt_q;
`ifdef MUX_PARITY_EN
    par_d   = par_q;
`endif
    if (load) begin
      y_d     = sel_word;
      gnt_d   = cidx;
      y_vld_d = 1'b1;
`ifdef MUX_PARITY_EN
      par_d   = ^sel_word;
`endif
      if (mode == MODE_RR) begin
        ptr_d = cidx;
      end
    end else if (rdy) begin
      y_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= SW'(N - 1);
      y_q     <= '0;
      y_vld_q <= 1'b0;
      gnt_q   <= '0;
`ifdef MUX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      ptr_q   <= ptr_d;
      y_q     <= y_d;
      y_vld_q <= y_vld_d;
      gnt_q   <= gnt_d;
`ifdef MUX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign y     = y_q;
  assign y_vld = y_vld_q;
  assign gnt   = gnt_q;
`ifdef MUX_PARITY_EN
  assign y_par = par_q;
`endif

endmodule

// File: tb/tb_mux_nto1_rr.sv
// Scoreboard bench for mux_nto1_rr: driver predicts loads/acks, monitor checks consumed words.
module tb_mux_nto1_rr;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned SW = $clog2(N);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N*W-1:0] din = '0;
  logic [N-1:0]   v = '0;
  logic [SW-1:0]  s = '0;
  logic           mode = 1'b0;
  logic           rdy = 1'b0;
  logic [N-1:0]   ack;
  logic [W-1:0]   y;
  logic           y_vld;
  logic [SW-1:0]  gnt;
`ifdef MUX_PARITY_EN
  logic           y_par;
`endif

  always #5 clk = ~clk;

  mux_nto1_rr #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .I     (din),
    .v     (v),
    .s     (s),
    .mode  (mode),
    .rdy   (rdy),
    .ack   (ack),
    .y     (y),
    .y_vld (y_vld),
`ifdef MUX_PARITY_EN
    .y_par (y_par),
`endif
    .gnt   (gnt)
  );

  typedef struct {
    logic [W-1:0] d;
    int           g;
    logic         p;
  } exp_t;

  exp_t         sb_q[$];
  int           n_cmp = 0;
  int           n_fail = 0;
  bit           m_vld = 0;
  int           m_ptr = N - 1;
  logic [W-1:0] m_last = '0;
  logic [N-1:0] last_ack = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arbitration rule: index of the winning channel, or -1 for none.
  function automatic int pick(input logic [N-1:0] vv, input int sv, input logic md, input int ptr);
    if (md == 1'b0) begin
      if (sv < N && vv[sv]) return sv;
      return -1;
    end
    for (int o = 1; o <= N; o++) begin
      if (vv[(ptr + o) % N]) return (ptr + o) % N;
    end
    return -1;
  endfunction

  function automatic logic [N*W-1:0] pack4(input logic [W-1:0] b0, input logic [W-1:0] b1,
                                           input logic [W-1:0] b2, input logic [W-1:0] b3);
    return {b3, b2, b1, b0};
  endfunction

  // One clock of stimulus; expected ack is checked and any predicted load queued.
  task automatic step(input logic r, input logic [N-1:0] vv, input logic [N*W-1:0] dd,
                      input logic [SW-1:0] ss, input logic md, input logic rd);
    int           k;
    bit           ld;
    logic [N-1:0] exp_ack;
    exp_t         e;
    @(negedge clk);
    rst = r; v = vv; din = dd; s = ss; mode = md; rdy = rd;
    #2;
    if (r) begin
      check("ack_in_reset", 64'(ack), 64'(0));
      sb_q.delete();
      m_vld    = 0;
      m_ptr    = N - 1;
      last_ack = '0;
    end else begin
      k       = pick(vv, int'(ss), md, m_ptr);
      ld      = (!m_vld || rd) && (k >= 0);
      exp_ack = ld ? (N'(1) << k) : '0;
      check("ack", 64'(ack), 64'(exp_ack));
      if (ld) begin
        e.d = dd[k*W +: W];
        e.g = k;
        e.p = ^e.d;
        sb_q.push_back(e);
        m_vld  = 1;
        m_last = e.d;
        if (md) m_ptr = k;
      end else if (rd) begin
        m_vld = 0;
      end
      last_ack = exp_ack;
    end
  endtask

  // Monitor: occupancy each cycle, payload whenever the consumer takes a word.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        check("y_vld", 64'(y_vld), 64'(sb_q.size() != 0));
        if (y_vld && rdy && sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("y", 64'(y), 64'(e.d));
          check("gnt", 64'(gnt), 64'(e.g));
`ifdef MUX_PARITY_EN
          check("y_par", 64'(y_par), 64'(e.p));
`endif
        end
      end
    end
  end

  initial begin
    logic         src_has[N];
    logic [W-1:0] src_dat[N];
    logic [N-1:0] vv;
    logic [N*W-1:0] dd;

    // Reset with all channels valid
    step(1'b1, 4'b1111, pack4(8'h11, 8'h22, 8'h33, 8'h44), '0, 1'b1, 1'b1);
    step(1'b1, 4'b1111, pack4(8'h11, 8'h22, 8'h33, 8'h44), '0, 1'b1, 1'b1);
    check("rst_y", 64'(y), 64'(0));
    check("rst_y_vld", 64'(y_vld), 64'(0));
    check("rst_gnt", 64'(gnt), 64'(0));

    // Round-robin wrap with all valid, then a sparse valid pattern
    for (int i = 0; i < 6; i++)
      step(1'b0, 4'b1111, pack4(W'(8'h10 + i), W'(8'h20 + i), W'(8'h30 + i), W'(8'h40 + i)),
           '0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++)
      step(1'b0, 4'b1010, pack4(8'h00, W'(8'h50 + i), 8'h00, W'(8'h60 + i)), '0, 1'b1, 1'b1);

    // Drain to empty; y must hold its last value
    step(1'b0, 4'b0000, '0, '0, 1'b1, 1'b1);
    step(1'b0, 4'b0000, '0, '0, 1'b1, 1'b1);
    check("drain_y_hold", 64'(y), 64'(m_last));

    // Fixed select, then backpressure, then release
    step(1'b0, 4'b0100, pack4(8'h00, 8'h00, 8'hA5, 8'h00), SW'(2), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b1111, pack4(8'h01, 8'h02, 8'h03, 8'h04), SW'(1), 1'b0, 1'b0);
      check("bp_y", 64'(y), 64'(8'hA5));
      check("bp_gnt", 64'(gnt), 64'(2));
    end
    step(1'b0, 4'b1111, pack4(8'h01, 8'h02, 8'h03, 8'h04), SW'(1), 1'b0, 1'b1);

    // Parity words
    step(1'b0, 4'b0001, pack4(8'h07, 8'h00, 8'h00, 8'h00), SW'(0), 1'b0, 1'b1);
    step(1'b0, 4'b0001, pack4(8'h03, 8'h00, 8'h00, 8'h00), SW'(0), 1'b0, 1'b1);
    step(1'b0, 4'b0000, '0, '0, 1'b0, 1'b1);

    // Randomized sources holding each word until acknowledged
    for (int k = 0; k < N; k++) begin
      src_has[k] = 1'b0;
      src_dat[k] = '0;
    end
    for (int it = 0; it < 400; it++) begin
      for (int k = 0; k < N; k++) begin
        if (last_ack[k]) src_has[k] = 1'b0;
        if (!src_has[k] && $urandom_range(0, 1) == 1) begin
          src_has[k] = 1'b1;
          src_dat[k] = W'($urandom);
        end
        vv[k]        = src_has[k];
        dd[k*W +: W] = src_dat[k];
      end
      step(it == 200, vv, dd, SW'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0);
    end

    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, '0, 1'b1, 1'b1);
    @(negedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_nto1_rr.md
# mux_nto1_rr

Parametrised N-to-1 channel multiplexer with a registered, handshaked output stage and two selection modes: fixed select, or round-robin arbitration across valid channels. It generalises the plain 2-to-1 select mux into the datapath funnel that merges several producer channels into one consumer stream. Each accepted word is acknowledged back to its source channel.

## Interface

Parameters:
- N, 4, number of input channels (N >= 2)
- W, 8, data width per channel
- SW, $clog2(N), select/grant width (localparam, not overridable)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- I  input  N*W  packed channel data; channel k occupies I[k*W +: W]
- v  input  N  per-channel valid
- s  input  SW  channel select, used in fixed mode only
- mode  input  1  0 = fixed select, 1 = round-robin
- rdy  input  1  consumer ready
- ack  output  N  one-hot; bit k high in the cycle channel k's word is loaded (combinational)
- y  output  W  registered output data
- y_vld  output  1  output register holds a valid word
- gnt  output  SW  index of the channel whose word is in y

The clock is `clk`; the reset is `rst`, synchronous and active-high.

## Operation

- Output stage is a one-entry buffer: y, y_vld, gnt.
- Load condition `ld_ok` = !y_vld || rdy.
- Fixed mode: if `ld_ok` and s < N and v[s]:
  - load y = I[s] and gnt = s
  - assert ack[s]
- Round-robin mode: if `ld_ok`, search channels starting at ptr+1 and wrapping modulo N for the first k with v[k]:
  - load y = I[k] and gnt = k, assert ack[k]
  - update ptr = k
- ptr updates only on a round-robin load. Fixed-mode loads leave ptr unchanged.
- No candidate while `ld_ok` is true: y_vld <= 0 if rdy consumed the held word, otherwise unchanged. y and gnt hold their last values.
- y_vld && !rdy: y, gnt and y_vld all hold. ack = 0 and no channel is consumed.
- y_vld && rdy with a candidate present: back-to-back transfer. Drain and load happen in the same cycle.
- s >= N (N not a power of 2): treated as no candidate. No load, no ack.
- mode change: applies to the next load only. The held word is unaffected.
- Sources must keep v[k] and data stable until ack[k].

## Timing

- Reset values:
  - y = 0, y_vld = 0, gnt = 0, ack = 0
  - ptr = N-1, so the first round-robin search starts at channel 0
- Reset asserted mid-hold discards the held word. y_vld = 0 in the cycle after rst is sampled.
- Latency: a word sampled with ack[k] at edge t appears on y with y_vld = 1 after edge t.
- Throughput: 1 word/cycle while rdy stays high.
- ack is combinational from v, s, mode, ptr, y_vld and rdy. It has no combinational path from I.
- Round-robin fairness: with all channels valid and rdy = 1, grants cycle 0,1,…,N-1,0. Worst-case wait is N-1 loads.

## Configuration

- `MUX_PARITY_EN` defined:
  - adds output port y_par (1 bit), = ^ of the word loaded into y
  - registered together with y and held with it; reset value 0
- `MUX_PARITY_EN` undefined: port y_par and its register are absent. All other behaviour is identical.

## Structure

- Package `mux_pkg`:
  - MODE_FIXED = 1'b0, MODE_RR = 1'b1
  - function for the packed-channel slice index
- Sub-module `rr_pick`:
  - inputs: v [N-1:0], ptr [SW-1:0]
  - outputs: found (1), idx [SW-1:0]
  - purely combinational rotate-and-priority search
- Top module holds ptr, the output register and the ack decode.

## Test plan

Defaults N=4, W=8.

- Reset: rst=1 for 2 cycles with v=4'b1111 -> y=0, y_vld=0, gnt=0, ack=0. After release with mode=1, first ack=4'b0001.
- Fixed mode: mode=0, s=2, I channel 2=8'hA5, v=4'b0100, rdy=1 -> ack=4'b0100, next cycle y=8'hA5, gnt=2, y_vld=1.
- Backpressure: y_vld=1, rdy=0 for 3 cycles while v=4'b1111 -> y, gnt stable, ack=0. rdy=1 -> next word loads that same cycle.
- Round-robin wrap: mode=1, v=4'b1111, rdy=1 for 6 cycles -> gnt sequence 0,1,2,3,0,1. With v=4'b1010 after a grant to channel 3 -> next gnts 1,3,1.
- Drain and empty: single word held, v=0, rdy=1 -> y_vld=0 next cycle, y unchanged.
- Parity (`MUX_PARITY_EN` defined): load 8'h07 -> y_par=1; load 8'h03 -> y_par=0.
